// File: rtl/shared_memory.sv
// -----------------------------------------------------------------------------
// shared_memory
//
// Two-channel shared word memory with a round-robin arbiter. Each cycle at
// most one channel reaches the single-access storage array. The granted
// channel sees a one-cycle ready pulse in the following cycle. For a read,
// rdata carries the word alongside that pulse.
//
// Handshake (valid/ready, per channel n):
//   The requester raises valid[n] together with wr_rd/addr/wdata/be. It holds
//   all of them stable until it samples ready[n]=1, and may then drop valid[n]
//   or present the next request. A channel is eligible only while
//   valid[n]=1 and ready[n]=0. This stops the arbiter from serving a request
//   a second time in the cycle where its completion is still visible.
//
// Ports:
//   clk    in   1             clock, rising edge
//   rst    in   1             synchronous active-high reset
//   valid  in   2             request per channel (bit n = channel n)
//   wr_rd  in   2             1 = write, 0 = read
//   addr   in   2*ADDR_WIDTH  word address, channel n uses slice n
//   wdata  in   2*WIDTH       write data, channel n uses slice n
//   be     in   2*BE_WIDTH    byte enables for writes, bit k = byte k
//   ready  out  2             registered completion pulse
//   rdata  out  2*WIDTH       registered read data, held until next read
//   err    out  2             out-of-range flag, only set with ready[n]
// -----------------------------------------------------------------------------
module shared_memory #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BE_WIDTH   = WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              valid,
  input  logic [1:0]              wr_rd,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*WIDTH-1:0]      wdata,
  input  logic [2*BE_WIDTH-1:0]   be,
  output logic [1:0]              ready,
  output logic [2*WIDTH-1:0]      rdata,
  output logic [1:0]              err
);

  // Storage array; reset clears every word.
  logic [WIDTH-1:0] mem [DEPTH];

  // Channel that wins when both are eligible. It points away from the most
  // recent grant and moves only when a grant happens.
  logic prio;

  // Arbitration
  logic [1:0] elig;
  logic       gnt_any;
  logic       gnt_ch;
  logic [1:0] gnt_vec;

  // Request fields of the granted channel
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic [BE_WIDTH-1:0]   sel_be;

  // Array access
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [WIDTH-1:0]      rd_word;
  logic [WIDTH-1:0]      wr_word;

  // ---------------------------------------------------------------------------
  // Arbiter: a lone eligible channel always wins. On contention, the channel
  // named by prio wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    elig    = valid & ~ready;
    gnt_any = 1'b0;
    gnt_ch  = 1'b0;
    case (elig)
      2'b01: begin
        gnt_any = 1'b1;
        gnt_ch  = 1'b0;
      end
      2'b10: begin
        gnt_any = 1'b1;
        gnt_ch  = 1'b1;
      end
      2'b11: begin
        gnt_any = 1'b1;
        gnt_ch  = prio;
      end
      default: begin
        gnt_any = 1'b0;
        gnt_ch  = 1'b0;
      end
    endcase

    gnt_vec = 2'b00;
    if (gnt_any) begin
      gnt_vec = gnt_ch ? 2'b10 : 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Select the granted channel's request fields.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (gnt_ch) begin
      sel_wr    = wr_rd[1];
      sel_addr  = addr[ADDR_WIDTH +: ADDR_WIDTH];
      sel_wdata = wdata[WIDTH +: WIDTH];
      sel_be    = be[BE_WIDTH +: BE_WIDTH];
    end else begin
      sel_wr    = wr_rd[0];
      sel_addr  = addr[0 +: ADDR_WIDTH];
      sel_wdata = wdata[0 +: WIDTH];
      sel_be    = be[0 +: BE_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Address check and byte merge. DEPTH need not be a power of two, so the
  // address field can name words that do not exist. Such accesses get a
  // zeroed index, so the array is never indexed out of bounds. The write
  // enable and read data are gated on in_range separately.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_range = ({1'b0, sel_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    idx      = in_range ? sel_addr : '0;
    rd_word  = mem[idx];
    wr_word  = rd_word;
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (sel_be[k]) begin
        wr_word[8*k +: 8] = sel_wdata[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State update. Reset wins over any grant in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      ready <= 2'b00;
      err   <= 2'b00;
      rdata <= '0;
      prio  <= 1'b0;
    end else begin
      ready <= gnt_vec;
      err   <= in_range ? 2'b00 : gnt_vec;
      if (gnt_any) begin
        prio <= ~gnt_ch;
        if (sel_wr) begin
          if (in_range) begin
            mem[idx] <= wr_word;
          end
        end else begin
          // Out-of-range reads return zero. rdata of the other channel holds.
          if (gnt_ch) begin
            rdata[WIDTH +: WIDTH] <= in_range ? rd_word : '0;
          end else begin
            rdata[0 +: WIDTH] <= in_range ? rd_word : '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/shared_memory.md
SHARED_MEMORY -- requirements
Module: shared_memory

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 16: number of words; need not be a power of 2.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH): address width per channel.
REQ-004 Parameter BE_WIDTH, default WIDTH/8: byte-enable bits per channel.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, as the following two port entries state.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 valid  input  2  request per channel; bit n is channel n.
REQ-009 wr_rd  input  2  per channel: 1 = write, 0 = read.
REQ-010 addr  input  2*ADDR_WIDTH  per-channel word address; channel n uses slice n.
REQ-011 wdata  input  2*WIDTH  per-channel write data.
REQ-012 be  input  2*BE_WIDTH  per-channel byte enables; bit k covers byte k.
REQ-013 ready  output  2  per-channel completion pulse, registered.
REQ-014 rdata  output  2*WIDTH  per-channel read data, registered.
REQ-015 err  output  2  per-channel out-of-range flag; valid only while ready[n]=1.

Function
REQ-016 Storage SHALL be a single-access array of DEPTH x WIDTH; at most one channel SHALL access it per cycle.
REQ-017 A requester SHALL hold valid[n], wr_rd, addr, wdata and be stable until it samples ready[n]=1, then may drop valid[n].
REQ-018 Eligible channels SHALL be those with valid[n]=1 and ready[n]=0 in that cycle, which prevents double service of a held request.
REQ-019 The arbiter SHALL grant one eligible channel per cycle; ready[granted] SHALL be 1 in the next cycle for exactly one cycle.
REQ-020 If both channels are eligible, the channel not granted most recently SHALL win; the priority pointer SHALL update only on a grant.
REQ-021 If only one channel is eligible, it SHALL be granted, whatever the priority pointer says.
REQ-022 Fairness: when both channels request continuously, grants SHALL alternate 0,1,0,1; a waiting channel SHALL be granted within 2 cycles of becoming eligible.
REQ-023 Write grant: for each k with be bit k = 1, mem[addr] byte k SHALL take wdata byte k; other bytes unchanged; rdata[n] unchanged.
REQ-024 A write with be all zero SHALL leave memory unchanged and still produce a ready pulse.
REQ-025 Read grant: rdata[n] SHALL take mem[addr], with 1-cycle latency, valid alongside ready[n]; be is ignored on reads.
REQ-026 rdata[n] SHALL hold its value until the next read grant to channel n.
REQ-027 A read granted after a write to the same address, in any later cycle, SHALL return the written data.
REQ-028 When addr >= DEPTH: no memory change; a read SHALL return rdata[n]=0; ready[n] and err[n] SHALL both pulse.
REQ-029 err[n] SHALL be 0 in every cycle other than an out-of-range completion.
REQ-030 With no eligible channel, memory, rdata and the priority pointer SHALL be unchanged, and ready SHALL be 0.

Reset
REQ-031 While rst=1: ready=0, err=0, rdata=0, all memory words=0, priority pointer favours channel 0.
REQ-032 rst SHALL override all requests in the same cycle; a request granted in the cycle rst rises SHALL produce no ready and no memory change.
REQ-033 After rst falls, held requests SHALL be re-arbitrated from the reset priority, with the first ready no earlier than 1 cycle after the first non-reset edge.

Verification
REQ-034 Reset, then both channels read addr 3 simultaneously -> ready=01 in cycle 1, ready=10 in cycle 2, both rdata=0x0000.
REQ-035 Ch0 writes 0xBEEF to addr 5 with be=11, then ch1 reads addr 5 -> ch1 rdata=0xBEEF with ready[1] pulse.
REQ-036 Addr 5 holds 0xBEEF, ch0 writes 0x1234 with be=01, then reads -> rdata=0xBE34.
REQ-037 Both channels hold valid high for 8 cycles with back-to-back requests -> grants alternate 0,1,0,1; no channel's ready is high 2 cycles in a row.
REQ-038 DEPTH=12, ch1 writes to addr 13, then reads addr 13 -> err[1] with each ready; rdata=0; memory unchanged.
REQ-039 Assert rst in the cycle a write to addr 2 is granted -> no ready pulse; addr 2 reads 0x0000 after reset.
